seg_chase_animator: RTL and testbench

//  Parametrised successor of the fixed 4-digit figure-eight chaser. Steps a single lit

---
 rtl/seg_chase_pkg.sv | 24 ++
 rtl/seg_step_timer.sv | 29 ++
 rtl/seg_chase_animator.sv | 119 +++++++++++
 tb/tb_seg_chase_animator.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_chase_pkg.sv
// Shared constants and helpers for the segment chase animator.
// Segment masks are active-low over {a,b,c,d,e,f,g,dp}; seg[7] is segment a.
package seg_chase_pkg;

    localparam logic [7:0] SEG_A   = 8'h7F;
    localparam logic [7:0] SEG_B   = 8'hBF;
    localparam logic [7:0] SEG_C   = 8'hDF;
    localparam logic [7:0] SEG_D   = 8'hEF;
    localparam logic [7:0] SEG_E   = 8'hF7;
    localparam logic [7:0] SEG_F   = 8'hFB;
    localparam logic [7:0] SEG_G   = 8'hFD;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic {
        PATH_FIG8  = 1'b0,
        PATH_PERIM = 1'b1
    } path_t;

    // Number of positions on a path for a display of the given digit count.
    function automatic int path_len(input int digits, input path_t mode);
        return (mode == PATH_PERIM) ? (2 * digits + 4) : (4 * digits + 4);
    endfunction

endpackage

// File: rtl/seg_step_timer.sv
// Divides CLK down to one-cycle step strobes every STEP_CYCLES enabled cycles.
// The strobe is asserted during the cycle whose edge advances the animation.
module seg_step_timer #(
    parameter int STEP_CYCLES = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    output logic step
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Step fires on the last count of an enabled period; en=0 also masks it.
    assign step = en && (cnt == LAST);

    // Count enabled cycles, rolling over at the step; disabled cycles hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seg_chase_animator.sv
// Steps a single lit segment around an N-digit multiplexed 7-segment display,
// either along a figure-eight or around the outer perimeter. The path mode is
// only taken up at a wrap so a lap is never cut short mid-path.
module seg_chase_animator
    import seg_chase_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int STEP_CYCLES = 1
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              en,
    input  logic                              dir,
    input  logic                              mode,
    output logic [7:0]                        seg,
    output logic [DIGITS-1:0]                 an,
    output logic [$clog2(4*DIGITS+4)-1:0]     pos,
    output logic                              wrap
);

    localparam int PW = $clog2(4 * DIGITS + 4);

    logic          step;
    path_t         mode_q;
    path_t         mode_in;
    logic [PW-1:0] last_cur;
    logic [PW-1:0] last_new;
    int            k;
    int            dig;

    seg_step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_timer (
        .CLK  (CLK),
        .RST  (RST),
        .en   (en),
        .step (step)
    );

    assign mode_in = path_t'(mode);

    // Last index of the path in use, and of the path requested for the next lap.
    assign last_cur = PW'(path_len(DIGITS, mode_q) - 1);
    assign last_new = PW'(path_len(DIGITS, mode_in) - 1);

    // Advance the position on each step; a wrap in either direction picks up the new mode.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pos    <= '0;
            mode_q <= mode_in;
            wrap   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (step) begin
                if (!dir) begin
                    if (pos == last_cur) begin
                        pos    <= '0;
                        mode_q <= mode_in;
                        wrap   <= 1'b1;
                    end else begin
                        pos <= pos + PW'(1);
                    end
                end else begin
                    if (pos == '0) begin
                        pos    <= last_new;
                        mode_q <= mode_in;
                        wrap   <= 1'b1;
                    end else begin
                        pos <= pos - PW'(1);
                    end
                end
            end
        end
    end

    // Map (pos, mode_q) to the lit segment and the digit that carries it.
    always_comb begin
        k   = int'(pos);
        seg = SEG_OFF;
        dig = 0;
        if (mode_q == PATH_FIG8) begin
            if (k < DIGITS) begin
                seg = SEG_A; dig = k;
            end else if (k == DIGITS) begin
                seg = SEG_B; dig = DIGITS - 1;
            end else if (k < 2 * DIGITS + 1) begin
                seg = SEG_G; dig = 2 * DIGITS - k;
            end else if (k == 2 * DIGITS + 1) begin
                seg = SEG_E; dig = 0;
            end else if (k < 3 * DIGITS + 2) begin
                seg = SEG_D; dig = k - (2 * DIGITS + 2);
            end else if (k == 3 * DIGITS + 2) begin
                seg = SEG_C; dig = DIGITS - 1;
            end else if (k < 4 * DIGITS + 3) begin
                seg = SEG_G; dig = 4 * DIGITS + 2 - k;
            end else begin
                seg = SEG_F; dig = 0;
            end
        end else begin
            if (k < DIGITS) begin
                seg = SEG_A; dig = k;
            end else if (k == DIGITS) begin
                seg = SEG_B; dig = DIGITS - 1;
            end else if (k == DIGITS + 1) begin
                seg = SEG_C; dig = DIGITS - 1;
            end else if (k < 2 * DIGITS + 2) begin
                seg = SEG_D; dig = 2 * DIGITS + 1 - k;
            end else if (k == 2 * DIGITS + 2) begin
                seg = SEG_E; dig = 0;
            end else begin
                seg = SEG_F; dig = 0;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            an[i] = (i != dig);
        end
    end

endmodule

// File: tb/tb_seg_chase_animator.sv
// Bench for seg_chase_animator: two instances (4 digits / 4 cycles per step and
// 8 digits / 1 cycle per step) share one stimulus stream. A reference model built
// from the path description predicts every cycle; a negedge monitor compares.
module tb_seg_chase_animator;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST  = 1'b1;
    logic en   = 1'b0;
    logic dir  = 1'b0;
    logic mode = 1'b0;

    logic [7:0] seg4, seg8;
    logic [3:0] an4;
    logic [7:0] an8;
    logic [4:0] pos4;
    logic [5:0] pos8;
    logic       wrap4, wrap8;

    seg_chase_animator #(.DIGITS(4), .STEP_CYCLES(4)) dut4 (
        .CLK(CLK), .RST(RST), .en(en), .dir(dir), .mode(mode),
        .seg(seg4), .an(an4), .pos(pos4), .wrap(wrap4)
    );

    seg_chase_animator #(.DIGITS(8), .STEP_CYCLES(1)) dut8 (
        .CLK(CLK), .RST(RST), .en(en), .dir(dir), .mode(mode),
        .seg(seg8), .an(an8), .pos(pos8), .wrap(wrap8)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] seg4;
        logic [3:0] an4;
        logic [4:0] pos4;
        logic       wrap4;
        logic [7:0] seg8;
        logic [7:0] an8;
        logic [5:0] pos8;
        logic       wrap8;
    } exp_t;

    exp_t exp_q[$];

    int ndig[2]  = '{4, 8};
    int nstep[2] = '{4, 1};

    logic [7:0] tab_seg[2][2][36];
    int         tab_dig[2][2][36];
    int         tab_len[2][2];

    int   m_cnt[2];
    int   m_pos[2];
    int   m_mode[2];
    logic m_wrap[2];

    int n_cmp = 0;
    int n_err = 0;

    // Active-low mask for segment index 0=a .. 6=g, with dp off.
    function automatic logic [7:0] sm(input int idx);
        logic [7:0] one;
        one = 8'h80;
        return ~(one >> idx);
    endfunction

    // Lay out a path as an ordered list of (segment, digit) pairs.
    task automatic build_path(input int i, input int md);
        logic [7:0] qs[$];
        int         qd[$];
        int         n;
        n = ndig[i];
        for (int d = 0; d < n; d++) begin qs.push_back(sm(0)); qd.push_back(d); end
        qs.push_back(sm(1)); qd.push_back(n - 1);
        if (md == 0) begin
            for (int d = n - 1; d >= 0; d--) begin qs.push_back(sm(6)); qd.push_back(d); end
            qs.push_back(sm(4)); qd.push_back(0);
            for (int d = 0; d < n; d++) begin qs.push_back(sm(3)); qd.push_back(d); end
            qs.push_back(sm(2)); qd.push_back(n - 1);
            for (int d = n - 1; d >= 0; d--) begin qs.push_back(sm(6)); qd.push_back(d); end
            qs.push_back(sm(5)); qd.push_back(0);
        end else begin
            qs.push_back(sm(2)); qd.push_back(n - 1);
            for (int d = n - 1; d >= 0; d--) begin qs.push_back(sm(3)); qd.push_back(d); end
            qs.push_back(sm(4)); qd.push_back(0);
            qs.push_back(sm(5)); qd.push_back(0);
        end
        tab_len[i][md] = qs.size();
        for (int k = 0; k < qs.size(); k++) begin
            tab_seg[i][md][k] = qs[k];
            tab_dig[i][md][k] = qd[k];
        end
    endtask

    // Predict state after one clock edge with the given inputs.
    function automatic void model_update(input int i, input logic r, input logic e,
                                         input logic d, input logic m);
        logic step;
        int   len;
        if (r) begin
            m_cnt[i] = 0; m_pos[i] = 0; m_mode[i] = int'(m); m_wrap[i] = 1'b0;
            return;
        end
        step = 1'b0;
        m_wrap[i] = 1'b0;
        if (e) begin
            if (m_cnt[i] == nstep[i] - 1) begin m_cnt[i] = 0; step = 1'b1; end
            else m_cnt[i] = m_cnt[i] + 1;
        end
        if (step) begin
            len = tab_len[i][m_mode[i]];
            if (!d) begin
                if (m_pos[i] == len - 1) begin
                    m_pos[i] = 0; m_mode[i] = int'(m); m_wrap[i] = 1'b1;
                end else m_pos[i] = m_pos[i] + 1;
            end else begin
                if (m_pos[i] == 0) begin
                    m_mode[i] = int'(m);
                    m_pos[i]  = tab_len[i][m_mode[i]] - 1;
                    m_wrap[i] = 1'b1;
                end else m_pos[i] = m_pos[i] - 1;
            end
        end
    endfunction

    // ---------------- driver ----------------
    task automatic tick(input logic r, input logic e, input logic d, input logic m);
        exp_t x;
        RST = r; en = e; dir = d; mode = m;
        @(posedge CLK);
        for (int i = 0; i < 2; i++) model_update(i, r, e, d, m);
        x.seg4  = tab_seg[0][m_mode[0]][m_pos[0]];
        x.an4   = ~(4'b0001 << tab_dig[0][m_mode[0]][m_pos[0]]);
        x.pos4  = 5'(m_pos[0]);
        x.wrap4 = m_wrap[0];
        x.seg8  = tab_seg[1][m_mode[1]][m_pos[1]];
        x.an8   = ~(8'b0000_0001 << tab_dig[1][m_mode[1]][m_pos[1]]);
        x.pos8  = 6'(m_pos[1]);
        x.wrap8 = m_wrap[1];
        exp_q.push_back(x);
        #1;
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    exp_t mon_e;
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("seg4",  seg4,        mon_e.seg4);
            chk("an4",   {4'h0, an4}, {4'h0, mon_e.an4});
            chk("pos4",  {3'h0, pos4}, {3'h0, mon_e.pos4});
            chk("wrap4", {7'h0, wrap4}, {7'h0, mon_e.wrap4});
            chk("seg8",  seg8,        mon_e.seg8);
            chk("an8",   an8,         mon_e.an8);
            chk("pos8",  {2'h0, pos8}, {2'h0, mon_e.pos8});
            chk("wrap8", {7'h0, wrap8}, {7'h0, mon_e.wrap8});
        end
    end

    // ---------------- stimulus ----------------
    logic cur_dir;
    logic cur_mode;
    logic cur_en;
    logic cur_rst;

    initial begin
        for (int i = 0; i < 2; i++) begin
            build_path(i, 0);
            build_path(i, 1);
            m_cnt[i] = 0; m_pos[i] = 0; m_mode[i] = 0; m_wrap[i] = 1'b0;
        end

        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);
        // forward figure-eight laps
        repeat (100) tick(1'b0, 1'b1, 1'b0, 1'b0);
        // freeze, then resume
        repeat (50)  tick(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (30)  tick(1'b0, 1'b1, 1'b0, 1'b0);
        // reverse through the origin
        repeat (100) tick(1'b0, 1'b1, 1'b1, 1'b0);
        // perimeter requested mid-lap, both directions
        repeat (150) tick(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (100) tick(1'b0, 1'b1, 1'b1, 1'b1);
        // reset while running
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (20)  tick(1'b0, 1'b1, 1'b0, 1'b0);

        // randomized run
        cur_dir = 1'b0; cur_mode = 1'b0;
        repeat (3000) begin
            if ($urandom_range(0, 15) == 0) cur_dir  = ~cur_dir;
            if ($urandom_range(0, 19) == 0) cur_mode = ~cur_mode;
            cur_en  = ($urandom_range(0, 9) != 0);
            cur_rst = ($urandom_range(0, 199) == 0);
            tick(cur_rst, cur_en, cur_dir, cur_mode);
        end

        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(negedge CLK);
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
